motor_drive_stage: RTL

Output stage downstream of the PMC. Consumes the controller's selected `speed_o`/`dir_o` and turns them into a 4-bit-resolution PWM line plus a direction bus and a brake strobe. Speed is slew-limited (soft ramp), and every direction reversal passes through a forced decelerate → dead-time → re-latch sequence. This keeps sudden PMC mode or fault switch-overs from reaching the actuator as instantaneous speed or direction steps.

---
 rtl/motor_drive_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/motor_drive_stage.sv
// Actuator output stage: slew-limited speed ramp, PWM generation and a
// decelerate / dead-time / re-latch sequence on every direction reversal.
module motor_drive_stage #(
  parameter int RAMP_DIV = 4,
  parameter int DEAD     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] speed,
  input  logic [3:0] dir,
  output logic       pwm_o,
  output logic [3:0] dir_o,
  output logic       brake_o,
  output logic [3:0] speed_cur,
  output logic       busy
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DECEL = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t        state_r;
  logic [PW-1:0] pre_r;
  logic [3:0]    pc_r;
  logic [DW-1:0] dcnt_r;
  logic          tick_s;

  assign tick_s = (pre_r == PRE_MAX);
  assign busy   = (state_r != ST_RUN) || (speed_cur != speed);

  // Free-running ramp prescaler, independent of the sequencing state
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= '0;
    end else if (tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  // PWM period counter, 0..14
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= 4'd0;
    end else if (pc_r == 4'd14) begin
      pc_r <= 4'd0;
    end else begin
      pc_r <= pc_r + 4'd1;
    end
  end

  // Sequencing FSM with ramp, direction latch, brake and PWM outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      speed_cur <= 4'd0;
      dir_o     <= 4'd0;
      brake_o   <= 1'b0;
      dcnt_r    <= '0;
      pwm_o     <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (dir == dir_o) begin
            if (tick_s && (speed_cur < speed)) begin
              speed_cur <= speed_cur + 4'd1;
            end else if (tick_s && (speed_cur > speed)) begin
              speed_cur <= speed_cur - 4'd1;
            end else begin
              speed_cur <= speed_cur;
            end
          end else if (speed_cur != 4'd0) begin
            state_r <= ST_DECEL;
          end else begin
            state_r <= ST_DEAD;
            dcnt_r  <= DEAD_LOAD;
            brake_o <= 1'b1;
          end
        end
        ST_DECEL: begin
          // A returning direction cancels the reversal before any dead time
          if (dir == dir_o) begin
            state_r <= ST_RUN;
          end else if (speed_cur == 4'd0) begin
            state_r <= ST_DEAD;
            dcnt_r  <= DEAD_LOAD;
            brake_o <= 1'b1;
          end else if (tick_s) begin
            speed_cur <= speed_cur - 4'd1;
          end else begin
            speed_cur <= speed_cur;
          end
        end
        ST_DEAD: begin
          if (dcnt_r == '0) begin
            dir_o   <= dir;
            brake_o <= 1'b0;
            state_r <= ST_RUN;
          end else begin
            dcnt_r <= dcnt_r - DW'(1);
          end
        end
        default: begin
          state_r <= ST_RUN;
          brake_o <= 1'b0;
        end
      endcase
      pwm_o <= (state_r != ST_DEAD) && (pc_r < speed_cur);
    end
  end

endmodule
